// File: rtl/fft_dit_ctrl_if.sv
// Control/address bundle between the radix-2 DIT FFT sequencer and its
// sample RAM, twiddle ROM and butterfly pipeline.
interface fft_dit_ctrl_if #(
    parameter int N_LOG2 = 4
);
    localparam int SW = $clog2(N_LOG2 + 1);

    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic [SW-1:0]     stage;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr_a;
    logic [N_LOG2-1:0] rd_addr_b;
    logic [N_LOG2-2:0] tw_addr;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_a;
    logic [N_LOG2-1:0] wr_addr_b;

    modport master (
        output start, hold,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, hold,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_dit_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly read per cycle,
// replays the addresses as write-backs PIPE_LAT cycles later.
module fft_dit_ctrl #(
    parameter int N_LOG2   = 4,
    parameter int PIPE_LAT = 2
) (
    input logic            clk,
    input logic            rst,
    fft_dit_ctrl_if.slave  bus
);
    localparam int SW = $clog2(N_LOG2 + 1);
    localparam int BW = N_LOG2 - 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [SW-1:0]     r_s;
    logic [BW-1:0]     r_b;
    logic [DW-1:0]     r_dcnt;
    logic [PIPE_LAT-1:0] r_dl_en;
    logic [N_LOG2-1:0] r_dl_a [PIPE_LAT];
    logic [N_LOG2-1:0] r_dl_b [PIPE_LAT];

    logic              w_issue;
    logic              w_rd_en;
    logic              w_last_b;
    logic              w_last_s;
    logic              w_drain_end;
    logic [BW-1:0]     w_jmask;
    logic [BW-1:0]     w_j;
    logic [BW-1:0]     w_g;
    logic [BW-1:0]     w_tw;
    logic [N_LOG2-1:0] w_h;
    logic [N_LOG2-1:0] w_a;
    logic [N_LOG2-1:0] w_b;

    assign w_issue     = (r_state == S_ISSUE);
    assign w_rd_en     = w_issue & ~bus.hold;
    assign w_last_b    = (r_b == {BW{1'b1}});
    assign w_last_s    = (r_s == SW'(N_LOG2 - 1));
    assign w_drain_end = (r_dcnt == DW'(PIPE_LAT - 1));

    // a = g*2h + j, b = a + h; bit s of a is always 0 so b = a | h
    always_comb begin
        w_jmask = ~({BW{1'b1}} << r_s);
        w_j     = r_b & w_jmask;
        w_g     = r_b >> r_s;
        w_h     = N_LOG2'(1) << r_s;
        w_a     = ({1'b0, w_g} << (r_s + 1'b1)) | {1'b0, w_j};
        w_b     = w_a | w_h;
        w_tw    = w_j << (SW'(BW) - r_s);
    end

    assign bus.busy      = (r_state == S_ISSUE) | (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.stage     = r_s;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr_a = w_issue ? w_a : '0;
    assign bus.rd_addr_b = w_issue ? w_b : '0;
    assign bus.tw_addr   = w_issue ? w_tw : '0;
    assign bus.wr_en     = r_dl_en[PIPE_LAT-1];
    assign bus.wr_addr_a = r_dl_a[PIPE_LAT-1];
    assign bus.wr_addr_b = r_dl_b[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_b     <= '0;
            r_dcnt  <= '0;
            r_dl_en <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_dl_a[i] <= '0;
                r_dl_b[i] <= '0;
            end
        end else begin
            // write-back delay line never stalls
            r_dl_en[0] <= w_rd_en;
            r_dl_a[0]  <= w_issue ? w_a : '0;
            r_dl_b[0]  <= w_issue ? w_b : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_dl_en[i] <= r_dl_en[i-1];
                r_dl_a[i]  <= r_dl_a[i-1];
                r_dl_b[i]  <= r_dl_b[i-1];
            end

            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_ISSUE;
                        r_s     <= '0;
                        r_b     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!bus.hold) begin
                        if (w_last_b) begin
                            r_b     <= '0;
                            r_dcnt  <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_b <= r_b + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_end) begin
                        r_dcnt <= '0;
                        if (w_last_s) begin
                            r_state <= S_DONE;
                            r_s     <= '0;
                        end else begin
                            r_state <= S_ISSUE;
                            r_s     <= r_s + 1'b1;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= bus.start ? S_ISSUE : S_IDLE;
                    r_s     <= '0;
                    r_b     <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_dit_ctrl.sv
// Bench for fft_dit_ctrl: per-cycle schedule model with random hold/start,
// chained restart, mid-transform reset and a small N=4 instance.
module tb_fft_dit_ctrl;
    localparam int NL   = 4;
    localparam int PL   = 2;
    localparam int NB   = (1 << NL) / 2;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_dit_ctrl_if #(.N_LOG2(NL)) bus ();
    fft_dit_ctrl #(.N_LOG2(NL), .PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fft_dit_ctrl_if #(.N_LOG2(2)) bus2 ();
    fft_dit_ctrl #(.N_LOG2(2), .PIPE_LAT(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit hold_arr [MAXC];
    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_rd   [MAXC];
    bit e_iss  [MAXC];
    bit e_wr   [MAXC];
    int e_stage [MAXC];
    int e_a  [MAXC];
    int e_b  [MAXC];
    int e_tw [MAXC];
    int e_wa [MAXC];
    int e_wb [MAXC];
    int e_end;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle schedule, cycle 1 = first cycle after start
    task automatic build(input int hp);
        int c;
        for (int i = 0; i < MAXC; i++) begin
            hold_arr[i] = (hp > 0 && i > 0 && i < 120) ?
                          ($urandom_range(0, 99) < hp) : 1'b0;
            e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_iss[i] = 0;
            e_wr[i] = 0; e_stage[i] = 0; e_a[i] = 0; e_b[i] = 0;
            e_tw[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
        end
        c = 1;
        for (int s = 0; s < NL; s++) begin
            for (int b = 0; b < NB; b++) begin
                int h, g, j, a, bb, tw;
                h  = 1 << s;
                g  = b / h;
                j  = b % h;
                a  = g * 2 * h + j;
                bb = a + h;
                tw = j * (1 << (NL - 1 - s));
                do begin
                    e_busy[c] = 1; e_stage[c] = s; e_iss[c] = 1;
                    e_a[c] = a; e_b[c] = bb; e_tw[c] = tw;
                    e_rd[c] = !hold_arr[c];
                    c++;
                end while (!e_rd[c-1]);
                e_wr[c-1+PL] = 1;
                e_wa[c-1+PL] = a;
                e_wb[c-1+PL] = bb;
            end
            for (int d = 0; d < PL; d++) begin
                e_busy[c] = 1; e_stage[c] = s;
                c++;
            end
        end
        e_done[c] = 1;
        e_end = c;
    endtask

    task automatic check_cycle(input int c);
        chk($sformatf("busy@%0d", c), 32'(bus.busy), 32'(e_busy[c]));
        chk($sformatf("done@%0d", c), 32'(bus.done), 32'(e_done[c]));
        chk($sformatf("stage@%0d", c), 32'(bus.stage), e_stage[c]);
        chk($sformatf("rd_en@%0d", c), 32'(bus.rd_en), 32'(e_rd[c]));
        chk($sformatf("wr_en@%0d", c), 32'(bus.wr_en), 32'(e_wr[c]));
        if (e_iss[c]) begin
            chk($sformatf("rd_a@%0d", c), 32'(bus.rd_addr_a), e_a[c]);
            chk($sformatf("rd_b@%0d", c), 32'(bus.rd_addr_b), e_b[c]);
            chk($sformatf("tw@%0d", c), 32'(bus.tw_addr), e_tw[c]);
        end
        if (e_wr[c]) begin
            chk($sformatf("wr_a@%0d", c), 32'(bus.wr_addr_a), e_wa[c]);
            chk($sformatf("wr_b@%0d", c), 32'(bus.wr_addr_b), e_wb[c]);
        end
    endtask

    task automatic run(input int hp, input bit chained, input bit restart);
        build(hp);
        if (!chained) begin
            bus.start = 1'b1;
            bus.hold  = 1'b0;
            @(negedge clk);
            chk("c0_busy", 32'(bus.busy), 0);
            chk("c0_rd_en", 32'(bus.rd_en), 0);
            @(posedge clk); #1;
        end
        for (int c = 1; c <= e_end; c++) begin
            bus.hold  = hold_arr[c];
            bus.start = (c == e_end) ? restart : ($urandom_range(0, 7) == 0);
            @(negedge clk);
            check_cycle(c);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        if (!restart) begin
            @(negedge clk);
            chk("post_busy", 32'(bus.busy), 0);
            chk("post_done", 32'(bus.done), 0);
            chk("post_rd", 32'(bus.rd_en), 0);
            chk("post_wr", 32'(bus.wr_en), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.start = 1'b0;  bus.hold = 1'b0;
        bus2.start = 1'b0; bus2.hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_stage", 32'(bus.stage), 0);
        chk("rst_rd", 32'(bus.rd_en), 0);
        chk("rst_wr", 32'(bus.wr_en), 0);
        chk("rst_addr", 32'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                             bus.wr_addr_a, bus.wr_addr_b}), 0);
        @(posedge clk); #1;

        // N=4, PIPE_LAT=1 instance: done in cycle 1 + 2*(2+1)
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        cyc = 1;
        while (cyc < 50) begin
            @(negedge clk);
            if (bus2.done) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("n4_done_cycle", cyc, 7);
        @(posedge clk); #1;

        run(0, 1'b0, 1'b0);
        run(25, 1'b0, 1'b1);
        run(0, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0);
        run(50, 1'b0, 1'b0);

        // abort mid stage 1 with writes in flight
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 14; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 15; c < 21; c++) begin
            @(negedge clk);
            chk($sformatf("abort_busy@%0d", c), 32'(bus.busy), 0);
            chk($sformatf("abort_rd@%0d", c), 32'(bus.rd_en), 0);
            chk($sformatf("abort_wr@%0d", c), 32'(bus.wr_en), 0);
            chk($sformatf("abort_stage@%0d", c), 32'(bus.stage), 0);
            @(posedge clk); #1;
        end
        run(0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
